decode_stage: RTL and testbench
===============================

# decode_stage

Registered, back-pressured RV32I/RV32E decode stage. It sits between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and decodes the full RV32I base set (OP, OP-IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, FENCE, SYSTEM). It holds issue while a source register has an outstanding write, using an internal scoreboard that write-back clears.

## Interface
- GP_REG_COUNT, 32: architectural registers; 32 (RV32I) or 16 (RV32E); REG_AW = $clog2(GP_REG_COUNT)
- ILLEGAL_STALLS, 0: 1 = illegal instruction also holds in_ready low until flush
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous kill of held output; has priority over all other events
- in_valid_i  in  1  fetch presents instruction
- in_ready_o  out  1  stage accepts this cycle
- instr_i  in  RISCV_WORD_WIDTH  instruction word
- instr_addr_i  in  RISCV_ADDR_WIDTH  instruction PC
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute consumes bundle
- pc_o  out  RISCV_ADDR_WIDTH  registered PC
- rf_rs1_addr_o, rf_rs2_addr_o, rf_rd_addr_o  out  REG_AW each  register indices
- rf_we_o  out  1  instruction writes rd (forced 0 when rd = 0 or illegal)
- rf_write_sel_o  out  1  RF_WRITE_ALU_OUT / RF_WRITE_MEM (loads)
- alu_op_o  out  ALU_OP_WIDTH  ALU_* encoding; ALU_SUB is added to riscv_defines
- operand_a_sel_o, operand_b_sel_o  out  2 each  ALU_OP_SEL_RF_1/RF_2/IMM/PC
- imm_o  out  RISCV_WORD_WIDTH  selected, sign-extended immediate
- mem_re_o, mem_we_o  out  1 each  load / store
- mem_size_o  out  3  funct3 of load/store
- branch_o, jump_o  out  1 each  conditional branch (cmp = funct3) / JAL or JALR
- illegal_inst_o  out  1  undefined encoding
- wb_valid_i  in  1  write-back retires a write
- wb_rd_i  in  REG_AW  retiring register

## Operation
- Output register. Accept fires when in_valid_i && in_ready_o. On accept, the decoded bundle is loaded into the output register and out_valid_o is set. When out_valid_o && out_ready_i && !accept, out_valid_o clears.
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i && !(ILLEGAL_STALLS && out_valid_o && illegal_inst_o).
- Scoreboard: GP_REG_COUNT pending bits; bit 0 is hard-wired 0.
  - Set bit rd on accept when the decoded rf_we = 1.
  - Clear bit wb_rd_i on wb_valid_i.
  - If set and clear target the same register in the same cycle, set wins.
- Hazard = (uses_rs1 && pending[rs1]) || (uses_rs2 && pending[rs2]), evaluated on instr_i.
  - uses_rs1: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: OP, STORE, BRANCH.
  - A wb_valid_i clear in the same cycle does not unblock; the check uses the registered pending bits.
- Decode:
  - OP-IMM: same ALU mapping as OP, with imm I-type. SLLI/SRLI/SRAI use shamt = instr[24:20]. Shifts with funct7 other than 0x00/0x20 are illegal.
  - OP: funct7 0x00 selects ADD, SLL, LTS, LTU, XOR, SRL, OR, AND. funct7 0x20 with funct3 000 selects SUB; with 101 selects SRA. Anything else is illegal.
  - LUI: ALU_PASS, a = IMM, U-immediate.
  - AUIPC: ALU_ADD, a = PC, b = IMM.
  - LOAD: ADD, b = IMM, I-immediate, mem_re, RF_WRITE_MEM. Legal funct3 are 000/001/010/100/101.
  - STORE: ADD, S-immediate, mem_we, no rd write. Legal funct3 are 000/001/010.
  - BRANCH: SB-immediate; funct3 010/011 are illegal.
  - JAL: UJ-immediate, a = PC, jump, rd write. JALR: I-immediate, jump; funct3 ≠ 000 is illegal.
  - FENCE and SYSTEM: no-ops, no rd write.
  - Any other opcode, or instr[1:0] ≠ 11, is illegal.
- RV32E: when GP_REG_COUNT = 16, any used rs1/rs2/rd field with bit 4 set is illegal.
- Illegal instruction: illegal_inst_o = 1, rf_we_o = mem_re_o = mem_we_o = branch_o = jump_o = 0, and no scoreboard set.
- Flush: clears out_valid_o and blocks accept that cycle. The scoreboard is unaffected.

## Timing
- Latency: 1 cycle from accept to out_valid_o. Throughput is 1 per cycle when there is no hazard and execute is ready.
- Reset values:
  - out_valid_o = 0; in_ready_o follows from this and is 1 while in reset.
  - All bundle outputs = 0, including alu_op_o = 0 and illegal_inst_o = 0.
  - Scoreboard all 0.
- Bundle outputs change only on accept and stay stable while out_valid_o && !out_ready_i.
- Reset asserted mid-stall drops the held bundle and all pending bits immediately.

## Test plan
- Back-to-back ADDI x1,x0,5 then ADDI x2,x0,7 with out_ready_i = 1 → out_valid_o on consecutive cycles; imm_o = 5 then 7; alu_op_o = ALU_ADD.
- ADDI x1,x0,1 then ADD x3,x1,x1, no write-back → second instruction is held with in_ready_o = 0. After wb_valid_i with wb_rd_i = 1, it is accepted on the following cycle.
- out_ready_i = 0 for 3 cycles with SW x2,8(x1) held → bundle stable with mem_we_o = 1, imm_o = 8, rf_we_o = 0, and in_ready_o = 0 throughout.
- Word 0x0000_0000, then SRAI with funct7 = 0x10 → illegal_inst_o = 1, rf_we_o = 0, scoreboard unchanged.
- GP_REG_COUNT = 16: ADDI x17,x0,1 → illegal. ADDI x15,x0,1 → legal with rf_rd_addr_o = 15.
- Same-cycle wb_valid_i on x5 and accept of LUI x5 → pending[5] remains set. Assert flush_i with a bundle held → out_valid_o = 0 on the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered, back-pressured RV32I/RV32E decode stage.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush_i                   kills the held bundle, blocks accept this cycle
//   in_valid_i / in_ready_o   fetch handshake (instr_i, instr_addr_i)
//   out_valid_o / out_ready_i execute handshake (registered decoded bundle)
//   pc_o, rf_*_o, alu_op_o, operand_*_sel_o, imm_o, mem_*_o,
//   branch_o, jump_o, illegal_inst_o   decoded bundle fields
//   wb_valid_i, wb_rd_i       write-back retires a pending register
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready_o never depends on in_valid_i; out_valid_o, once set,
// stays high with a stable bundle until out_ready_i is seen, or until flush.

package riscv_defines;
  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int ALU_OP_WIDTH     = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_LTS  = 4'd3;
  localparam logic [3:0] ALU_LTU  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [1:0] ALU_OP_SEL_RF_1 = 2'd0;
  localparam logic [1:0] ALU_OP_SEL_RF_2 = 2'd1;
  localparam logic [1:0] ALU_OP_SEL_IMM  = 2'd2;
  localparam logic [1:0] ALU_OP_SEL_PC   = 2'd3;

  localparam logic RF_WRITE_ALU_OUT = 1'b0;
  localparam logic RF_WRITE_MEM     = 1'b1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

module decode_stage
  import riscv_defines::*;
#(
  parameter int GP_REG_COUNT   = 32,
  parameter bit ILLEGAL_STALLS = 1'b0,
  localparam int REG_AW        = $clog2(GP_REG_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [RISCV_WORD_WIDTH-1:0] instr_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] instr_addr_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0] pc_o,
  output logic [REG_AW-1:0]           rf_rs1_addr_o,
  output logic [REG_AW-1:0]           rf_rs2_addr_o,
  output logic [REG_AW-1:0]           rf_rd_addr_o,
  output logic                        rf_we_o,
  output logic                        rf_write_sel_o,
  output logic [ALU_OP_WIDTH-1:0]     alu_op_o,
  output logic [1:0]                  operand_a_sel_o,
  output logic [1:0]                  operand_b_sel_o,
  output logic [RISCV_WORD_WIDTH-1:0] imm_o,
  output logic                        mem_re_o,
  output logic                        mem_we_o,
  output logic [2:0]                  mem_size_o,
  output logic                        branch_o,
  output logic                        jump_o,
  output logic                        illegal_inst_o,
  input  logic                        wb_valid_i,
  input  logic [REG_AW-1:0]           wb_rd_i
);

  localparam bit IS_RV32E = (GP_REG_COUNT == 16);

  typedef struct packed {
    logic [RISCV_ADDR_WIDTH-1:0] pc;
    logic [REG_AW-1:0]           rs1;
    logic [REG_AW-1:0]           rs2;
    logic [REG_AW-1:0]           rd;
    logic                        we;
    logic                        wsel;
    logic [ALU_OP_WIDTH-1:0]     alu;
    logic [1:0]                  asel;
    logic [1:0]                  bsel;
    logic [RISCV_WORD_WIDTH-1:0] imm;
    logic                        re;
    logic                        wem;
    logic [2:0]                  size;
    logic                        br;
    logic                        jmp;
    logic                        ill;
  } bundle_t;

  bundle_t                 dec;
  bundle_t                 bundle_d, bundle_q;
  logic                    out_valid_d, out_valid_q;
  logic [GP_REG_COUNT-1:0] pending_d, pending_q;
  logic                    uses_rs1, uses_rs2, writes_rd, illegal;
  logic                    hazard, accept;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // funct7 = 0x00 ALU mapping shared by OP and OP-IMM.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_LTS;
      3'b011:  return ALU_LTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin : decode
    dec       = '0;
    dec.pc    = instr_addr_i;
    dec.rs1   = instr_i[15 +: REG_AW];
    dec.rs2   = instr_i[20 +: REG_AW];
    dec.rd    = instr_i[7 +: REG_AW];
    dec.alu   = ALU_ADD;
    dec.asel  = ALU_OP_SEL_RF_1;
    dec.bsel  = ALU_OP_SEL_RF_2;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
        if (funct7 == 7'h00)                            dec.alu = alu_from_f3(funct3);
        else if (funct7 == 7'h20 && funct3 == 3'b000)   dec.alu = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'b101)   dec.alu = ALU_SRA;
        else                                            illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1; writes_rd = 1'b1;
        dec.bsel = ALU_OP_SEL_IMM;
        dec.imm  = {{20{instr_i[31]}}, instr_i[31:20]};
        dec.alu  = alu_from_f3(funct3);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.imm = {27'd0, instr_i[24:20]};
          if (funct3 == 3'b101 && funct7 == 7'h20) dec.alu = ALU_SRA;
          else if (funct7 != 7'h00)                illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        writes_rd = 1'b1;
        dec.alu   = ALU_PASS;
        dec.asel  = ALU_OP_SEL_IMM;
        dec.imm   = {instr_i[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        writes_rd = 1'b1;
        dec.asel  = ALU_OP_SEL_PC;
        dec.bsel  = ALU_OP_SEL_IMM;
        dec.imm   = {instr_i[31:12], 12'd0};
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1; writes_rd = 1'b1;
        dec.bsel = ALU_OP_SEL_IMM;
        dec.imm  = {{20{instr_i[31]}}, instr_i[31:20]};
        dec.re   = 1'b1;
        dec.wsel = RF_WRITE_MEM;
        dec.size = funct3;
        illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.bsel = ALU_OP_SEL_IMM;
        dec.imm  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        dec.wem  = 1'b1;
        dec.size = funct3;
        illegal  = funct3[2] || (funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        dec.br   = 1'b1;
        illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        dec.asel  = ALU_OP_SEL_PC;
        dec.bsel  = ALU_OP_SEL_IMM;
        dec.imm   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        dec.jmp   = 1'b1;
      end
      OPC_JALR: begin
        uses_rs1 = 1'b1; writes_rd = 1'b1;
        dec.bsel = ALU_OP_SEL_IMM;
        dec.imm  = {{20{instr_i[31]}}, instr_i[31:20]};
        dec.jmp  = 1'b1;
        illegal  = (funct3 != 3'b000);
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase

    // RV32E has no x16..x31: any register field the instruction uses must keep bit 4 clear.
    if (IS_RV32E && ((uses_rs1 && instr_i[19]) || (uses_rs2 && instr_i[24]) ||
                     (writes_rd && instr_i[11])))
      illegal = 1'b1;

    // Illegal bundles carry only pc, raw register fields and the flag, so
    // execute never sees a half-decoded operation.
    if (illegal) begin
      dec.we   = 1'b0;
      dec.wsel = 1'b0;
      dec.alu  = '0;
      dec.asel = '0;
      dec.bsel = '0;
      dec.imm  = '0;
      dec.re   = 1'b0;
      dec.wem  = 1'b0;
      dec.size = '0;
      dec.br   = 1'b0;
      dec.jmp  = 1'b0;
      dec.ill  = 1'b1;
    end else begin
      dec.we   = writes_rd && (dec.rd != '0);
    end
  end

  // Hazard looks only at registered pending bits; a same-cycle write-back
  // releases the instruction one cycle later.
  assign hazard = (uses_rs1 && pending_q[dec.rs1]) || (uses_rs2 && pending_q[dec.rs2]);
  assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i &&
                      !(ILLEGAL_STALLS && out_valid_q && bundle_q.ill);
  assign accept = in_valid_i && in_ready_o;

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    pending_d   = pending_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (wb_valid_i) pending_d[wb_rd_i] = 1'b0;
    // Set is applied after clear so a same-register collision leaves the bit set.
    if (accept && dec.we) pending_d[dec.rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign pc_o            = bundle_q.pc;
  assign rf_rs1_addr_o   = bundle_q.rs1;
  assign rf_rs2_addr_o   = bundle_q.rs2;
  assign rf_rd_addr_o    = bundle_q.rd;
  assign rf_we_o         = bundle_q.we;
  assign rf_write_sel_o  = bundle_q.wsel;
  assign alu_op_o        = bundle_q.alu;
  assign operand_a_sel_o = bundle_q.asel;
  assign operand_b_sel_o = bundle_q.bsel;
  assign imm_o           = bundle_q.imm;
  assign mem_re_o        = bundle_q.re;
  assign mem_we_o        = bundle_q.wem;
  assign mem_size_o      = bundle_q.size;
  assign branch_o        = bundle_q.br;
  assign jump_o          = bundle_q.jmp;
  assign illegal_inst_o  = bundle_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (RV32I instance plus a
// small RV32E instance). Expected bundles come from a reference decoder.
module tb_decode_stage;
  import riscv_defines::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        we, wsel;
    logic [3:0]  alu;
    logic [1:0]  asel, bsel;
    logic [31:0] imm;
    logic        re, wem;
    logic [2:0]  size;
    logic        br, jmp, ill;
  } bundle_t;
  localparam int BW = $bits(bundle_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- RV32I DUT ----------------
  logic        flush_i = 0, in_valid_i = 0, out_ready_i = 0, wb_valid_i = 0;
  logic [31:0] instr_i = 0, instr_addr_i = 0;
  logic [4:0]  wb_rd_i = 0;
  logic        in_ready_o, out_valid_o, rf_we_o, rf_write_sel_o, mem_re_o, mem_we_o;
  logic        branch_o, jump_o, illegal_inst_o;
  logic [31:0] pc_o, imm_o;
  logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o, rf_rd_addr_o;
  logic [3:0]  alu_op_o;
  logic [1:0]  operand_a_sel_o, operand_b_sel_o;
  logic [2:0]  mem_size_o;

  decode_stage #(.GP_REG_COUNT(32), .ILLEGAL_STALLS(1'b0)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .instr_addr_i(instr_addr_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .rf_rs1_addr_o(rf_rs1_addr_o),
    .rf_rs2_addr_o(rf_rs2_addr_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_we_o(rf_we_o),
    .rf_write_sel_o(rf_write_sel_o), .alu_op_o(alu_op_o), .operand_a_sel_o(operand_a_sel_o),
    .operand_b_sel_o(operand_b_sel_o), .imm_o(imm_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_size_o(mem_size_o), .branch_o(branch_o), .jump_o(jump_o),
    .illegal_inst_o(illegal_inst_o), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i)
  );

  bundle_t dut_b;
  assign dut_b = {pc_o, rf_rs1_addr_o, rf_rs2_addr_o, rf_rd_addr_o, rf_we_o, rf_write_sel_o,
                  alu_op_o, operand_a_sel_o, operand_b_sel_o, imm_o, mem_re_o, mem_we_o,
                  mem_size_o, branch_o, jump_o, illegal_inst_o};

  // ---------------- RV32E DUT ----------------
  logic        e_in_valid = 0;
  logic [31:0] e_instr = 0;
  logic        e_in_ready, e_out_valid, e_rf_we, e_wsel, e_re, e_wem, e_br, e_jmp, e_ill;
  logic [31:0] e_pc, e_imm;
  logic [3:0]  e_rs1, e_rs2, e_rd, e_alu;
  logic [1:0]  e_asel, e_bsel;
  logic [2:0]  e_size;

  decode_stage #(.GP_REG_COUNT(16), .ILLEGAL_STALLS(1'b0)) dut_e (
    .clk(clk), .rst(rst), .flush_i(1'b0), .in_valid_i(e_in_valid), .in_ready_o(e_in_ready),
    .instr_i(e_instr), .instr_addr_i(32'h40), .out_valid_o(e_out_valid), .out_ready_i(1'b1),
    .pc_o(e_pc), .rf_rs1_addr_o(e_rs1), .rf_rs2_addr_o(e_rs2), .rf_rd_addr_o(e_rd),
    .rf_we_o(e_rf_we), .rf_write_sel_o(e_wsel), .alu_op_o(e_alu), .operand_a_sel_o(e_asel),
    .operand_b_sel_o(e_bsel), .imm_o(e_imm), .mem_re_o(e_re), .mem_we_o(e_wem),
    .mem_size_o(e_size), .branch_o(e_br), .jump_o(e_jmp), .illegal_inst_o(e_ill),
    .wb_valid_i(1'b0), .wb_rd_i(4'd0)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  logic          exp_valid = 1'b0;
  logic [31:0]   pend = '0;
  logic          mon_en = 1'b0;
  int            checks = 0;
  int            passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic uses1(input logic [6:0] op);
    return op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  endfunction
  function automatic logic uses2(input logic [6:0] op);
    return op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

  function automatic bundle_t model(input logic [31:0] w, input logic [31:0] pc);
    bundle_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ok, wr;
    logic [3:0] tab [8];
    logic [31:0] ii, is, ib, iu, ij;
    tab = '{ALU_ADD, ALU_SLL, ALU_LTS, ALU_LTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ii = 32'($signed(w[31:20]));
    is = 32'($signed({w[31:25], w[11:7]}));
    ib = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    iu = w & 32'hFFFF_F000;
    ij = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    b = '0; b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
    b.asel = ALU_OP_SEL_RF_1; b.bsel = ALU_OP_SEL_RF_2; b.alu = ALU_ADD;
    ok = 1'b1; wr = 1'b0;
    case (op)
      OPC_OP: begin
        wr = 1'b1;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        b.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : tab[f3];
      end
      OPC_OP_IMM: begin
        wr = 1'b1; b.bsel = ALU_OP_SEL_IMM; b.alu = tab[f3]; b.imm = ii;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b.imm = {27'd0, w[24:20]};
          ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
          if (f3 == 3'd5 && f7 == 7'h20) b.alu = ALU_SRA;
        end
      end
      OPC_LUI:   begin wr = 1'b1; b.alu = ALU_PASS; b.asel = ALU_OP_SEL_IMM; b.imm = iu; end
      OPC_AUIPC: begin wr = 1'b1; b.asel = ALU_OP_SEL_PC; b.bsel = ALU_OP_SEL_IMM; b.imm = iu; end
      OPC_LOAD: begin
        wr = 1'b1; b.bsel = ALU_OP_SEL_IMM; b.imm = ii; b.re = 1'b1; b.wsel = RF_WRITE_MEM;
        b.size = f3; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      OPC_STORE: begin
        b.bsel = ALU_OP_SEL_IMM; b.imm = is; b.wem = 1'b1; b.size = f3; ok = (f3 <= 3'd2);
      end
      OPC_BRANCH: begin b.imm = ib; b.br = 1'b1; ok = !(f3 == 3'd2 || f3 == 3'd3); end
      OPC_JAL: begin
        wr = 1'b1; b.asel = ALU_OP_SEL_PC; b.bsel = ALU_OP_SEL_IMM; b.imm = ij; b.jmp = 1'b1;
      end
      OPC_JALR: begin
        wr = 1'b1; b.bsel = ALU_OP_SEL_IMM; b.imm = ii; b.jmp = 1'b1; ok = (f3 == 3'd0);
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b = '0; b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.ill = 1'b1;
    end else begin
      b.we = wr && (b.rd != 5'd0);
    end
    return b;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        check("out_valid", out_valid_o, exp_valid);
        if (out_valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL bundle_unexpected: got bundle %0h expected none (t=%0t)", dut_b, $time);
          end else begin
            check("bundle", dut_b, exp_q[0]);
            if (out_ready_i || flush_i) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic wbv, input logic [4:0] wbrd,
                       input logic fl, output logic acc);
    logic er, hz, nv;
    logic [31:0] np;
    bundle_t m;
    in_valid_i = v; instr_i = w; instr_addr_i = pc; out_ready_i = ordy;
    wb_valid_i = wbv; wb_rd_i = wbrd; flush_i = fl;
    #1;
    hz = (uses1(w[6:0]) && pend[w[19:15]]) || (uses2(w[6:0]) && pend[w[24:20]]);
    er = (!exp_valid || ordy) && !hz && !fl;
    check("in_ready", in_ready_o, er);
    acc = v && er;
    m = model(w, pc);
    np = pend;
    if (wbv) np[wbrd] = 1'b0;
    if (acc && m.we) np[m.rd] = 1'b1;
    np[0] = 1'b0;
    nv = fl ? 1'b0 : (acc ? 1'b1 : (ordy ? 1'b0 : exp_valid));
    if (acc) exp_q.push_back(m);
    @(posedge clk);
    exp_valid = nv;
    pend = np;
    #1;
  endtask

  function automatic logic [4:0] pick_wb();
    int s;
    s = $urandom_range(0, 31);
    for (int k = 0; k < 32; k++)
      if (pend[(s + k) % 32]) return 5'((s + k) % 32);
    return 5'(s);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0] ops [11];
    int k;
    ops = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM};
    w = $urandom();
    k = $urandom_range(0, 11);
    if (k == 11) return w;
    w[6:0]   = ops[k];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if (ops[k] == OPC_OP || ops[k] == OPC_OP_IMM)
      case ($urandom_range(0, 3))
        0, 1:    w[31:25] = 7'h00;
        2:       w[31:25] = 7'h20;
        default: w[31:25] = 7'($urandom_range(0, 127));
      endcase
    if (ops[k] == OPC_JALR && $urandom_range(0, 3) != 0) w[14:12] = 3'd0;
    return w;
  endfunction

  // ---------------- main sequence ----------------
  localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] I_ADDI_X2_7  = 32'h0070_0113;
  localparam logic [31:0] I_ADDI_X1_1  = 32'h0010_0093;
  localparam logic [31:0] I_ADD_X3     = 32'h0010_81B3;
  localparam logic [31:0] I_SW         = 32'h0020_A423;
  localparam logic [31:0] I_ADDI_X5_1  = 32'h0010_0293;
  localparam logic [31:0] I_SRAI_BAD   = 32'h2030_D213;
  localparam logic [31:0] I_ADD_X6_X4  = 32'h0042_0333;
  localparam logic [31:0] I_LUI_X5     = 32'h1234_52B7;
  localparam logic [31:0] I_ADD_X6_X5  = 32'h0002_8333;
  localparam logic [31:0] I_ADDI_X9_3  = 32'h0030_0493;
  localparam logic [31:0] I_ADD_X4_X9  = 32'h0094_8233;

  initial begin
    logic acc, hold, v, ordy, fl, wbv;
    logic [31:0] w, pc;

    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_in_ready", in_ready_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_bundle", dut_b, '0);
    check("reset_alu_op", alu_op_o, 4'd0);
    check("reset_illegal", illegal_inst_o, 1'b0);
    mon_en = 1'b1;

    // RV32E: x17 is out of range, x15 is fine.
    e_in_valid = 1'b1; e_instr = 32'h0010_0893;
    #1 check("e_in_ready", e_in_ready, 1'b1);
    @(posedge clk); #1;
    check("e_x17_illegal", e_ill, 1'b1);
    check("e_x17_we", e_rf_we, 1'b0);
    check("e_x17_valid", e_out_valid, 1'b1);
    e_instr = 32'h0010_0793;
    @(posedge clk); #1;
    check("e_x15_illegal", e_ill, 1'b0);
    check("e_x15_rd", e_rd, 4'd15);
    check("e_x15_we", e_rf_we, 1'b1);
    e_in_valid = 1'b0;

    // Back-to-back ADDI.
    cycle(1, I_ADDI_X1_5, 32'h100, 1, 0, 0, 0, acc);
    check("addi5_imm", imm_o, 32'd5);
    check("addi5_alu", alu_op_o, ALU_ADD);
    cycle(1, I_ADDI_X2_7, 32'h104, 1, 0, 0, 0, acc);
    check("addi7_imm", imm_o, 32'd7);
    check("addi7_valid", out_valid_o, 1'b1);
    cycle(0, 0, 0, 1, 1, 5'd1, 0, acc);
    cycle(0, 0, 0, 1, 1, 5'd2, 0, acc);

    // RAW hold until write-back, released one cycle after it.
    cycle(1, I_ADDI_X1_1, 32'h108, 1, 0, 0, 0, acc);
    cycle(1, I_ADD_X3, 32'h10c, 1, 0, 0, 0, acc);
    cycle(1, I_ADD_X3, 32'h10c, 1, 0, 0, 0, acc);
    cycle(1, I_ADD_X3, 32'h10c, 1, 1, 5'd1, 0, acc);
    cycle(1, I_ADD_X3, 32'h10c, 1, 0, 0, 0, acc);
    check("raw_rd", rf_rd_addr_o, 5'd3);

    // Store held under back-pressure.
    cycle(1, I_SW, 32'h110, 1, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1, I_ADDI_X5_1, 32'h114, 0, 0, 0, 0, acc);
      check("sw_mem_we", mem_we_o, 1'b1);
      check("sw_imm", imm_o, 32'd8);
      check("sw_rf_we", rf_we_o, 1'b0);
    end
    cycle(1, I_ADDI_X5_1, 32'h114, 1, 0, 0, 0, acc);

    // Illegal encodings leave the scoreboard alone.
    cycle(1, 32'h0, 32'h118, 1, 0, 0, 0, acc);
    check("zero_illegal", illegal_inst_o, 1'b1);
    check("zero_we", rf_we_o, 1'b0);
    cycle(1, I_SRAI_BAD, 32'h11c, 1, 0, 0, 0, acc);
    check("srai_illegal", illegal_inst_o, 1'b1);
    check("srai_we", rf_we_o, 1'b0);
    cycle(1, I_ADD_X6_X4, 32'h120, 1, 0, 0, 0, acc);

    // Set wins over same-cycle clear; then flush a held bundle.
    cycle(1, I_LUI_X5, 32'h124, 1, 1, 5'd5, 0, acc);
    cycle(1, I_ADD_X6_X5, 32'h128, 1, 0, 0, 0, acc);
    cycle(1, I_ADD_X6_X5, 32'h128, 0, 1, 5'd5, 0, acc);
    cycle(1, I_ADD_X6_X5, 32'h128, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 1, acc);
    check("flush_valid", out_valid_o, 1'b0);

    // Randomized traffic.
    hold = 1'b0; v = 1'b0; w = 0; pc = 32'h1000;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        v  = ($urandom_range(0, 9) < 8);
        w  = gen_instr();
        pc = pc + 4;
      end
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 19) == 0);
      wbv  = $urandom_range(0, 1);
      cycle(v, w, pc, ordy, wbv, pick_wb(), fl, acc);
      hold = v && !acc;
    end

    // Drain, then reset in the middle of a stall.
    for (int n = 0; n < 40; n++) cycle(0, 0, 0, 1, 1, pick_wb(), 0, acc);
    cycle(1, I_ADDI_X9_3, 32'h200, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, acc);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid_o, 1'b0);
    check("midrst_pc", pc_o, 32'd0);
    check("midrst_ready", in_ready_o, 1'b1);
    exp_q.delete();
    exp_valid = 1'b0;
    pend = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, I_ADD_X4_X9, 32'h204, 1, 0, 0, 0, acc);
    check("postrst_valid", out_valid_o, 1'b1);
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 1, 0, 0, 0, acc);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
